// File: rtl/multiport_data_memory.sv
// multiport_data_memory: shared data RAM with byte-enable CPU port, buffered keyboard writes, registered video reads and a clear sweep
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr, busy       clear request pulse (RUN only), sweep in progress
//   we, be, a, wd   CPU write enable, byte enables, byte address, write data
//   rd              CPU combinational read data
//   kb_valid/ready  keyboard write handshake; kb_addr/kb_data captured on push
//   kb_last         data of the most recently committed keyboard write
//   vid_addr        N_RD packed video byte addresses
//   vid_data        N_RD packed registered video read data
//   oob_err         sticky out-of-range access flag
module multiport_data_memory #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 64,
    parameter int N_RD          = 2,
    parameter int KB_FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   we,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [31:0]            a,
    input  logic [DATA_W-1:0]      wd,
    output logic [DATA_W-1:0]      rd,
    input  logic                   kb_valid,
    output logic                   kb_ready,
    input  logic [31:0]            kb_addr,
    input  logic [DATA_W-1:0]      kb_data,
    output logic [DATA_W-1:0]      kb_last,
    input  logic [N_RD*32-1:0]     vid_addr,
    output logic [N_RD*DATA_W-1:0] vid_data,
    output logic                   oob_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(KB_FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int NB = DATA_W / 8;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [29:0]       fifo_addr [KB_FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [KB_FIFO_DEPTH];
    logic [FW-1:0]     wp, rp;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] vid_q [N_RD];
    logic [29:0]       head_w;
    logic              run, cpu_ok, cpu_wr, head_ok, push, drain;
    logic [N_RD-1:0]   unused_vid;
    logic              unused_bits;

    function automatic logic in_range(input logic [29:0] w);
        return w < 30'(DEPTH);
    endfunction

    assign run      = state == S_RUN;
    assign busy     = !run;
    assign cpu_ok   = in_range(a[31:2]);
    assign cpu_wr   = run && we && cpu_ok;
    assign head_w   = fifo_addr[rp];
    assign head_ok  = in_range(head_w);
    assign kb_ready = run && cnt != CW'(KB_FIFO_DEPTH);
    assign push     = kb_valid && kb_ready;
    // An in-range CPU write owns the single array write slot this cycle
    assign drain    = run && cnt != '0 && !cpu_wr;
    assign rd       = (run && cpu_ok) ? mem[a[AW+1:2]] : '0;

    for (genvar i = 0; i < N_RD; i++) begin : g_vid
        assign vid_data[DATA_W*i +: DATA_W] = vid_q[i];
        assign unused_vid[i] = ^vid_addr[32*i +: 2];
    end
    assign unused_bits = ^{a[1:0], kb_addr[1:0], unused_vid};

    always_ff @(posedge clk)
        if (!run)
            mem[ptr] <= '0;
        else if (cpu_wr) begin
            for (int k = 0; k < NB; k++)
                if (be[k]) mem[a[AW+1:2]][8*k +: 8] <= wd[8*k +: 8];
        end else if (drain && head_ok)
            mem[head_w[AW-1:0]] <= fifo_data[rp];

    always_ff @(posedge clk)
        if (push) begin
            fifo_addr[wp] <= kb_addr[31:2];
            fifo_data[wp] <= kb_data;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= S_CLEAR;
            ptr     <= '0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            kb_last <= '0;
            oob_err <= 1'b0;
            for (int i = 0; i < N_RD; i++) vid_q[i] <= '0;
        end else begin
            if (!run) begin
                ptr <= ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) state <= S_RUN;
            end else if (clr) begin
                state <= S_CLEAR;
                ptr   <= '0;
                wp    <= '0;
                rp    <= '0;
                cnt   <= '0;
            end else begin
                if (push) wp <= wp + FW'(1);
                if (drain) rp <= rp + FW'(1);
                cnt <= cnt + CW'(push) - CW'(drain);
            end
            if (drain && head_ok) kb_last <= fifo_data[rp];
            if (run && (!cpu_ok || (drain && !head_ok))) oob_err <= 1'b1;
            // Read-first: vid_q samples the array before this edge's write lands
            for (int i = 0; i < N_RD; i++)
                vid_q[i] <= (run && in_range(vid_addr[32*i+2 +: 30])) ? mem[vid_addr[32*i+2 +: AW]] : '0;
        end
endmodule
